keypad_move_ctrl: RTL

Debounces keypad scan results and turns them into Connect-4 move commands: one command per physical press, with optional pop mode. Sits between the keypad scanner (100 MHz `clk` domain) and the game-board logic. Move commands are delivered over a valid/ready handshake, so the board can stall input while it animates or checks a win.

---
 rtl/c4_pkg.sv | 15 +
 rtl/stable_counter.sv | 37 +++
 rtl/keypad_move_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/c4_pkg.sv
// Shared types and constants for the Connect-4 keypad front end.
package c4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_ISSUE    = 2'd2,
      ST_RELEASE  = 2'd3
   } kmc_state_t;

   localparam logic [3:0] KEY_POP     = 4'h0;
   localparam logic [3:0] KEY_CANCEL  = 4'hE;
   localparam int         C4_NUM_COLS = 7;

endpackage

// File: rtl/stable_counter.sv
// Saturating up-counter that flags when MAX_COUNT-1 consecutive increments
// have been seen; used for both press and release debounce.
module stable_counter #(
   parameter int unsigned MAX_COUNT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic done_o
);

   localparam int W = $clog2(MAX_COUNT);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign done_o = (cnt_q == W'(MAX_COUNT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !done_o) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/keypad_move_ctrl.sv
// Debounces keypad scan codes and issues one Connect-4 move (drop or pop)
// per physical press over a valid/ready handshake.
//
// state    | meaning
// IDLE     | no key held, waiting for a candidate press
// DEBOUNCE | candidate latched, counting stable cycles
// ISSUE    | move pending on the handshake, key activity ignored
// RELEASE  | waiting for the key to stay released long enough
module keypad_move_ctrl
   import c4_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int          NUM_COLS        = C4_NUM_COLS,
   parameter int          COL_W           = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       key_code,
   input  logic             key_valid,
   input  logic             en,
   output logic             move_valid,
   input  logic             move_ready,
   output logic [COL_W-1:0] move_col,
   output logic             move_pop,
   output logic             pop_armed,
   output logic             key_strobe,
   output logic [3:0]       key_last
);

   localparam logic [3:0] NUM_COLS_K = 4'(NUM_COLS);

   kmc_state_t       state_q, state_d;
   logic [3:0]       cand_q, cand_d;
   logic             move_valid_q, move_valid_d;
   logic [COL_W-1:0] move_col_q, move_col_d;
   logic             move_pop_q, move_pop_d;
   logic             pop_armed_q, pop_armed_d;
   logic             key_strobe_q, key_strobe_d;
   logic [3:0]       key_last_q, key_last_d;
   logic             cnt_clr, cnt_inc, cnt_done;

   stable_counter #(
      .MAX_COUNT(DEBOUNCE_CYCLES)
   ) u_stable_counter (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .inc_i (cnt_inc),
      .done_o(cnt_done)
   );

   always_comb begin
      state_d      = state_q;
      cand_d       = cand_q;
      move_valid_d = move_valid_q;
      move_col_d   = move_col_q;
      move_pop_d   = move_pop_q;
      pop_armed_d  = pop_armed_q;
      key_strobe_d = 1'b0;
      key_last_d   = key_last_q;
      cnt_clr      = 1'b0;
      cnt_inc      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (key_valid) begin
               cand_d  = key_code;
               state_d = ST_DEBOUNCE;
            end
         end

         ST_DEBOUNCE: begin
            if (!key_valid || (key_code != cand_q)) begin
               state_d = ST_IDLE;
            end else if (cnt_done) begin
               key_strobe_d = 1'b1;
               key_last_d   = cand_q;
               cnt_clr      = 1'b1;
               state_d      = ST_RELEASE;
               if (!en) begin
                  // accepted but consumed: strobe only
               end else if ((cand_q != 4'd0) && (cand_q <= NUM_COLS_K)) begin
                  move_valid_d = 1'b1;
                  move_col_d   = COL_W'(cand_q - 4'd1);
                  move_pop_d   = pop_armed_q;
                  state_d      = ST_ISSUE;
               end else if (cand_q == KEY_POP) begin
                  pop_armed_d = ~pop_armed_q;
               end else if (cand_q == KEY_CANCEL) begin
                  pop_armed_d = 1'b0;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end

         ST_ISSUE: begin
            cnt_clr = 1'b1;
            if (move_valid_q && move_ready) begin
               move_valid_d = 1'b0;
               pop_armed_d  = 1'b0;
               state_d      = ST_RELEASE;
            end
         end

         ST_RELEASE: begin
            if (key_valid) begin
               cnt_clr = 1'b1;
            end else if (cnt_done) begin
               state_d = ST_IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cand_q       <= '0;
         move_valid_q <= 1'b0;
         move_col_q   <= '0;
         move_pop_q   <= 1'b0;
         pop_armed_q  <= 1'b0;
         key_strobe_q <= 1'b0;
         key_last_q   <= '0;
      end else begin
         state_q      <= state_d;
         cand_q       <= cand_d;
         move_valid_q <= move_valid_d;
         move_col_q   <= move_col_d;
         move_pop_q   <= move_pop_d;
         pop_armed_q  <= pop_armed_d;
         key_strobe_q <= key_strobe_d;
         key_last_q   <= key_last_d;
      end
   end

   assign move_valid = move_valid_q;
   assign move_col   = move_col_q;
   assign move_pop   = move_pop_q;
   assign pop_armed  = pop_armed_q;
   assign key_strobe = key_strobe_q;
   assign key_last   = key_last_q;

endmodule
